// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed big-endian byte image into instruction memory
// and holds the processor in reset until the image has been written.
module imem_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLenHi = 3'd1;
  localparam logic [2:0] StLenLo = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;
  localparam logic [2:0] StErr   = 3'd6;

  // Words that fit between BASE_ADDR and the top of memory; wider than 16 bits on purpose.
  localparam logic [32:0]       MaxWords = (33'd1 << ADDR_W) - 33'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BaseWord = ADDR_W'(BASE_ADDR);

  logic [2:0]  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic [15:0] len_new;
  logic        accept;

  assign in_ready  = (state_q == StLenHi) || (state_q == StLenLo) || (state_q == StData);
  assign busy      = in_ready || (state_q == StWrite);
  assign accept    = in_valid && in_ready;
  assign mem_we    = (state_q == StWrite);
  assign mem_addr  = BaseWord + ADDR_W'(idx_q);
  assign mem_wdata = word_q;
  assign cpu_rst   = (state_q != StDone);
  assign done      = (state_q == StDone);
  assign err       = (state_q == StErr);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    len_new    = {len_q[15:8], in_data};
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) state_d = StLenHi;
      end
      StLenHi: begin
        if (accept) begin
          len_d   = {in_data, len_q[7:0]};
          state_d = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d = len_new;
          if (len_new == 16'd0) begin
            state_d = StDone;
          end else if ({17'd0, len_new} > MaxWords) begin
            state_d = StErr;
          end else begin
            state_d    = StData;
            idx_d      = 16'd0;
            byte_cnt_d = 2'd0;
          end
        end
      end
      StData: begin
        if (accept) begin
          word_d     = {word_q[23:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = StWrite;
        end
      end
      StWrite: begin
        if (idx_q + 16'd1 == len_q) begin
          state_d = StDone;
        end else begin
          idx_d      = idx_q + 16'd1;
          byte_cnt_d = 2'd0;
          state_d    = StData;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= 16'd0;
      idx_q      <= 16'd0;
      byte_cnt_q <= 2'd0;
      word_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

endmodule
